// File: rtl/frame_capture_ack_pkg.sv
// Shared definitions for the frame capture / ACK block.
//   - FSM state encoding (idle, waiting for start of frame, capturing)
//   - Avalon-MM register addresses
//   - STATUS register layout and bit indices
package frame_capture_ack_pkg;

    // FSM states
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitSof = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    // Register map
    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrWidth  = 2'd1;
    localparam logic [1:0] AddrHeight = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    // STATUS bit indices
    localparam int unsigned StatDone    = 0;
    localparam int unsigned StatTimeout = 1;
    localparam int unsigned StatLineErr = 2;
    localparam int unsigned StatCfgErr  = 3;

    // Sticky status bits, laid out to match STATUS[3:0]
    typedef struct packed {
        logic cfg_err;
        logic line_err;
        logic timeout;
        logic done;
    } status_t;

endpackage

// File: rtl/frame_capture_ack_counter.sv
// Pixel / line counter for one captured frame.
//   clk, reset_n      : clock, asynchronous active-low reset
//   clear             : zero both counters (capture being armed)
//   active            : counting enabled (capture in progress)
//   lval, pix_valid   : camera line valid and pixel strobe
//   width, height     : expected pixels per line and lines per frame
//   eol               : end of line (falling edge of lval)
//   line_mismatch     : eol with pixel count != width
//   frame_complete    : eol that finishes the height-th line
module frame_capture_ack_counter
    import frame_capture_ack_pkg::*;
#(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             active,
    input  logic             lval,
    input  logic             pix_valid,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic             eol,
    output logic             line_mismatch,
    output logic             frame_complete
);

    logic             lval_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W:0]   line_cnt_inc;

    assign eol = ~lval & lval_d;

    // One extra bit so a wrapped line count can never alias a valid height
    assign line_cnt_inc   = {1'b0, line_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign line_mismatch  = eol && (pix_cnt_q != width);
    assign frame_complete = eol && (line_cnt_inc == {1'b0, height});

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        if (clear) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
        end else if (active) begin
            if (eol) begin
                pix_cnt_d  = '0;
                line_cnt_d = line_cnt_inc[CNT_W-1:0];
            end else if (lval && pix_valid && (pix_cnt_q != {CNT_W{1'b1}})) begin
                pix_cnt_d = pix_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lval_d     <= 1'b0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            lval_d     <= lval;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

endmodule

// File: rtl/frame_capture_ack.sv
// Avalon-MM slave that arms a single-frame capture, tracks the camera timing and
// drives ack_out (high while armed or capturing, falling edge = frame done).
//   clk, reset_n                 : clock, asynchronous active-low reset
//   address, chipselect, write_n : Avalon-MM slave control
//   writedata, readdata          : write data, registered read data (1-cycle latency)
//   fval, lval, pix_valid        : camera frame valid, line valid, pixel strobe
//   ack_out                      : capture armed/busy indicator
module frame_capture_ack
    import frame_capture_ack_pkg::*;
#(
    parameter int unsigned CNT_W          = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        fval,
    input  logic        lval,
    input  logic        pix_valid,
    output logic        ack_out
);

    logic             wr, start, abort, stat_clr, cfg_ok;
    logic             fval_d, sof, fval_fall, timeout_hit;
    logic             cnt_clear, cnt_active;
    logic             eol, line_mismatch, frame_complete;
    logic [1:0]       state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] width_q, height_q;
    status_t          status_q, status_d, status_set;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:CNT_W];

    assign wr       = chipselect & ~write_n;
    assign start    = wr && (address == AddrCtrl) && writedata[0];
    assign abort    = wr && (address == AddrCtrl) && writedata[1];
    assign stat_clr = wr && (address == AddrStatus) && writedata[0];
    assign cfg_ok   = (width_q != '0) && (height_q != '0);

    assign sof         = fval & ~fval_d;
    assign fval_fall   = ~fval & fval_d;
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign cnt_active  = (state_q == StCapture);

    frame_capture_ack_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (cnt_clear),
        .active         (cnt_active),
        .lval           (lval),
        .pix_valid      (pix_valid),
        .width          (width_q),
        .height         (height_q),
        .eol            (eol),
        .line_mismatch  (line_mismatch),
        .frame_complete (frame_complete)
    );

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        cnt_clear  = 1'b0;
        status_set = '0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        state_d   = StWaitSof;
                        to_cnt_d  = '0;
                        cnt_clear = 1'b1;
                    end else begin
                        status_set.cfg_err = 1'b1;
                    end
                end
            end
            StWaitSof: begin
                // Only a rising fval starts capture, so a frame already in flight is skipped
                if (sof) state_d = StCapture;
            end
            StCapture: begin
                if (line_mismatch) status_set.line_err = 1'b1;
                if (frame_complete) begin
                    status_set.done = 1'b1;
                    state_d         = StIdle;
                end else if (fval_fall) begin
                    status_set.line_err = 1'b1;
                    state_d             = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout applies to both busy states and may coincide with done
        if (state_q != StIdle) begin
            to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            if (timeout_hit) begin
                status_set.timeout = 1'b1;
                state_d            = StIdle;
            end
        end

        // Abort overrides everything and reports nothing
        if (abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            status_set = '0;
        end
    end

    // A set in the same cycle as a clear wins
    assign status_d = (stat_clr ? status_t'('0) : status_q) | status_set;

    always_comb begin
        rd_mux = '0;
        unique case (address)
            AddrCtrl:   rd_mux[0]         = (state_q != StIdle);
            AddrWidth:  rd_mux[CNT_W-1:0] = width_q;
            AddrHeight: rd_mux[CNT_W-1:0] = height_q;
            AddrStatus: rd_mux[3:0]       = status_q;
            default:    rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            to_cnt_q <= '0;
            status_q <= '0;
            width_q  <= '0;
            height_q <= '0;
            fval_d   <= 1'b0;
            ack_out  <= 1'b0;
            readdata <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            status_q <= status_d;
            fval_d   <= fval;
            ack_out  <= (state_d != StIdle);
            readdata <= rd_mux;
            if (wr && (address == AddrWidth))  width_q  <= writedata[CNT_W-1:0];
            if (wr && (address == AddrHeight)) height_q <= writedata[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_frame_capture_ack.sv
module tb_frame_capture_ack;

    localparam int unsigned CNT_W  = 12;
    localparam int unsigned TO_CYC = 16;
    localparam int unsigned TO_W   = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        fval = 1'b0;
    logic        lval = 1'b0;
    logic        pix_valid = 1'b0;
    logic        ack_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_capture_ack #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (TO_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .fval       (fval),
        .lval       (lval),
        .pix_valid  (pix_valid),
        .ack_out    (ack_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = not busy, 1 = armed and waiting for a new frame, 2 = in the frame
    int          m_phase, m_pix, m_lines, m_armed, m_width, m_height;
    logic [3:0]  m_status;   // {cfg_err, line_err, timeout, done}
    logic        m_ack, m_fprev, m_lprev;
    logic [31:0] m_rd;

    task automatic m_reset();
        m_phase = 0; m_pix = 0; m_lines = 0; m_armed = 0;
        m_width = 0; m_height = 0; m_status = 4'h0;
        m_ack = 1'b0; m_fprev = 1'b0; m_lprev = 1'b0; m_rd = '0;
    endtask

    task automatic m_step();
        bit wr, start, abrt, clr, sof, eol, ffall, ended, last;
        logic [3:0] sets;
        wr    = chipselect && !write_n;
        start = wr && (address == 2'd0) && writedata[0];
        abrt  = wr && (address == 2'd0) && writedata[1];
        clr   = wr && (address == 2'd3) && writedata[0];
        sof   = fval && !m_fprev;
        eol   = !lval && m_lprev;
        ffall = !fval && m_fprev;
        sets  = 4'h0;
        ended = 1'b0;

        case (address)
            2'd0:    m_rd = {31'd0, m_phase != 0};
            2'd1:    m_rd = 32'(m_width);
            2'd2:    m_rd = 32'(m_height);
            default: m_rd = {28'd0, m_status};
        endcase

        if (abrt && m_phase != 0) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start && !abrt) begin
                if (m_width != 0 && m_height != 0) begin
                    m_phase = 1; m_pix = 0; m_lines = 0; m_armed = 0;
                end else begin
                    sets[3] = 1'b1;
                end
            end
        end else begin
            last = (m_armed == int'(TO_CYC) - 1);
            if (m_phase == 2) begin
                if (eol) begin
                    if (m_pix != m_width) sets[2] = 1'b1;
                    m_lines++;
                    m_pix = 0;
                    if (m_lines == m_height) begin
                        sets[0] = 1'b1;
                        ended   = 1'b1;
                    end
                end else if (lval && pix_valid && m_pix < 4095) begin
                    m_pix++;
                end
                if (ffall && !ended) begin
                    sets[2] = 1'b1;
                    ended   = 1'b1;
                end
            end else if (sof) begin
                m_phase = 2;
            end
            m_armed++;
            if (last) begin
                sets[1] = 1'b1;
                ended   = 1'b1;
            end
            if (ended) m_phase = 0;
        end

        if (wr && address == 2'd1) m_width  = int'(writedata[11:0]);
        if (wr && address == 2'd2) m_height = int'(writedata[11:0]);
        m_status = (clr ? 4'h0 : m_status) | sets;
        m_ack    = (m_phase != 0);
        m_fprev  = fval;
        m_lprev  = lval;
    endtask

    // Compare process: every clock (and on reset assertion)
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
            #1;
            check("ack_out", {31'd0, ack_out}, {31'd0, m_ack});
            check("readdata", readdata, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0;
        v = readdata;
    endtask

    task automatic drv(input logic f, input logic l, input logic p);
        @(negedge clk);
        fval = f; lval = l; pix_valid = p;
    endtask

    // n pixels with fval held high, then one blanking cycle (the eol)
    task automatic line(input int n);
        for (int i = 0; i < n; i++) drv(1'b1, 1'b1, 1'b1);
        drv(1'b1, 1'b0, 1'b0);
    endtask

    logic [31:0] v;
    int          n;

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            check($sformatf("reset read addr%0d", a), v, 32'h0);
        end
        check("reset ack", {31'd0, ack_out}, 32'h0);

        // Good 2x4 frame
        wr_reg(2'd1, 32'd4);
        wr_reg(2'd2, 32'd2);
        rd_reg(2'd1, v); check("width readback", v, 32'd4);
        wr_reg(2'd0, 32'd1);
        check("ack after start", {31'd0, ack_out}, 32'h1);
        drv(1'b1, 1'b0, 1'b0);
        line(4);
        line(4);
        check("ack before final eol edge", {31'd0, ack_out}, 32'h1);
        drv(1'b0, 1'b0, 1'b0);
        check("ack after final eol", {31'd0, ack_out}, 32'h0);
        rd_reg(2'd3, v); check("status good frame", v, 32'h1);

        // Short second line
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd0, 32'd1);
        drv(1'b1, 1'b0, 1'b0);
        line(4);
        line(3);
        drv(1'b0, 1'b0, 1'b0);
        check("ack after short frame", {31'd0, ack_out}, 32'h0);
        rd_reg(2'd3, v); check("status short line", v, 32'h5);
        wr_reg(2'd3, 32'd1);
        rd_reg(2'd3, v); check("status cleared", v, 32'h0);

        // Timeout with no frame
        wr_reg(2'd0, 32'd1);
        n = 0;
        while (ack_out && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout ack high cycles", 32'(n), 32'd16);
        rd_reg(2'd3, v); check("status timeout", v, 32'h2);
        wr_reg(2'd3, 32'd1);

        // Frame already running at arm time is skipped; then abort mid-capture
        wr_reg(2'd2, 32'd1);
        drv(1'b1, 1'b0, 1'b0);
        wr_reg(2'd0, 32'd1);
        line(4);
        rd_reg(2'd0, v); check("busy after skipped frame", v, 32'h1);
        drv(1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b1);
        drv(1'b1, 1'b1, 1'b1);
        wr_reg(2'd0, 32'd2);
        check("ack after abort", {31'd0, ack_out}, 32'h0);
        drv(1'b0, 1'b0, 1'b0);
        rd_reg(2'd3, v); check("status after abort", v, 32'h0);

        // eol completing the frame on the timeout terminal cycle: done and timeout
        wr_reg(2'd0, 32'd1);
        repeat (9) drv(1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b0, 1'b0);
        line(4);
        drv(1'b0, 1'b0, 1'b0);
        rd_reg(2'd3, v); check("status done+timeout", v, 32'h3);
        wr_reg(2'd3, 32'd1);

        // fval drops before all lines arrive
        wr_reg(2'd2, 32'd2);
        wr_reg(2'd0, 32'd1);
        drv(1'b1, 1'b0, 1'b0);
        line(4);
        drv(1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b0);
        check("ack after early fval fall", {31'd0, ack_out}, 32'h0);
        rd_reg(2'd3, v); check("status early fval fall", v, 32'h4);
        wr_reg(2'd3, 32'd1);

        // Zero height -> cfg_err; start+abort together stays idle
        wr_reg(2'd2, 32'd0);
        wr_reg(2'd0, 32'd1);
        check("ack cfg_err", {31'd0, ack_out}, 32'h0);
        rd_reg(2'd3, v); check("status cfg_err", v, 32'h8);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd2, 32'd2);
        wr_reg(2'd0, 32'd3);
        check("ack start+abort", {31'd0, ack_out}, 32'h0);
        rd_reg(2'd0, v); check("busy start+abort", v, 32'h0);
        rd_reg(2'd3, v); check("status start+abort", v, 32'h0);

        // Reset mid-capture
        wr_reg(2'd0, 32'd1);
        drv(1'b1, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("ack during reset", {31'd0, ack_out}, 32'h0);
        drv(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(2'd1, v); check("width after reset", v, 32'h0);
        rd_reg(2'd0, v); check("busy after reset", v, 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_capture_ack.md
Name: frame_capture_ack

Overview:
- Avalon-MM slave that arms a single-frame capture, counts pixels and lines from the camera timing signals, and drives ack_out.
- ack_out is high while a capture is armed or running, and falls when the capture ends.
- ack_out feeds the ACK edge-capture PIO input directly. Its falling edge is the CPU's "frame done" interrupt source.
- Sits between the camera timing interface and the ACK PIO in mysystem.

Parameters:
- CNT_W, 12: width of the WIDTH/HEIGHT registers and the pixel/line counters.
- TIMEOUT_CYCLES, 1000000: clk cycles allowed in WAIT_SOF+CAPTURE before the capture is forcibly ended.
- TO_W, 24: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- address, input, 2: register select.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data.
- readdata, output, 32: registered read data, 1-cycle latency, unused bits 0.
- fval, input, 1: frame valid, synchronous to clk.
- lval, input, 1: line valid, synchronous to clk.
- pix_valid, input, 1: pixel strobe, counted only while lval=1.
- ack_out, output, 1: high = capture armed or busy; high->low = capture ended.

Behaviour:
- Register map (wr = chipselect & ~write_n):
  - addr0 CTRL: write bit0 = start, bit1 = abort. Read bit0 = busy (state != IDLE).
  - addr1 WIDTH: R/W, CNT_W bits.
  - addr2 HEIGHT: R/W, CNT_W bits.
  - addr3 STATUS: read {cfg_err, line_err, timeout, done} in bits [3:0]. Writing 1 to bit0 clears all four sticky bits.
- readdata is registered every clk from the address mux, regardless of chipselect.
- Reset: state=IDLE, ack_out=0, readdata=0, WIDTH=0, HEIGHT=0, all counters and status bits 0.
- fval_d and lval_d are 1-cycle delayed copies of the inputs.
  - sof = fval & ~fval_d.
  - eol = ~lval & lval_d.
- FSM:
  - IDLE: start with WIDTH!=0 and HEIGHT!=0 -> WAIT_SOF. Clear pix_cnt, line_cnt, to_cnt.
  - IDLE: start with WIDTH==0 or HEIGHT==0 -> set cfg_err, stay IDLE.
  - WAIT_SOF: sof -> CAPTURE. A frame already in progress at arm time (fval=1) is skipped; only a rising edge starts capture.
  - CAPTURE: pix_cnt increments on lval & pix_valid, saturating at all-ones.
  - CAPTURE on eol:
    - If pix_cnt != WIDTH, set line_err.
    - Increment line_cnt and reset pix_cnt to 0.
    - If line_cnt+1 == HEIGHT: set done, go to IDLE.
  - CAPTURE: fval falling before HEIGHT lines -> set line_err, go to IDLE. done is not set.
  - WAIT_SOF or CAPTURE: to_cnt increments every cycle. At to_cnt == TIMEOUT_CYCLES-1, set timeout and go to IDLE.
- ack_out is registered and equals 1 in WAIT_SOF/CAPTURE, 0 in IDLE.
  - The sticky status bit and the ack_out low are set on the same clk edge.
  - ack_out falls 1 cycle after the terminating event.
- After ack_out falls it stays low for at least 1 cycle, even if start is written in the same cycle. Start is honoured only from IDLE.
- Simultaneous events:
  - abort and start in the same write: abort wins, state -> IDLE, no status bit set.
  - eol completing the frame and the timeout terminal count in the same cycle: done and timeout both set.
  - Status clear written in the same cycle as a status set: the set wins.
- Start while busy is ignored. Abort in IDLE has no effect. Abort while busy -> IDLE, ack_out falls, no status bit set.
- WIDTH/HEIGHT writes during a capture take effect immediately for comparisons. Software must not do this; there is no protection.
- reset_n low mid-capture: immediate IDLE, ack_out=0, all registers reset.

Decomposition:
- Shared package holds:
  - state encoding IDLE/WAIT_SOF/CAPTURE;
  - register address constants CTRL=0, WIDTH=1, HEIGHT=2, STATUS=3;
  - STATUS bit indices.
- Natural sub-module: frame_capture_ack_counter, holding pix_cnt/line_cnt with eol, line-end compare and frame-complete outputs.
- FSM, register file and timeout stay in the top module.

Test Plan:
- Reset, then read all four addresses -> readdata=0 one cycle after each read. ack_out=0.
- WIDTH=4, HEIGHT=2, start, then a frame of 2 lines x 4 pixels -> ack_out=1 from start+1. ack_out=0 one cycle after the 2nd eol. STATUS reads 0x1.
- WIDTH=4, HEIGHT=2, start, 2nd line has 3 pixels -> ack_out falls after the 2nd eol. STATUS=0x5 (done, line_err). Write STATUS=1 -> STATUS=0x0.
- TIMEOUT_CYCLES=16, start, no fval -> ack_out high for exactly 16 cycles, then 0. STATUS=0x2.
- fval=1 already at start -> no capture until fval falls and rises again. Abort mid-CAPTURE -> ack_out=0 next cycle, STATUS=0x0.
- HEIGHT=0, start -> ack_out stays 0, STATUS=0x8. Start+abort written together (writedata=3) -> stays IDLE.
